// File: rtl/fp_pkg.sv
// Shared types and constants for the FP adder datapath.
// Holds the single-precision word layout and exception flag indices.
package fp_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;

  localparam logic [EXP_W-1:0] EXP_MAX = {EXP_W{1'b1}};

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] mant;
  } fp_word_t;

  // {guard, round, sticky}
  typedef logic [2:0] grs_t;

  localparam int FLG_OVF = 1;
  localparam int FLG_INX = 0;

endpackage

// File: rtl/fp_rne_round.sv
// Combinational round-to-nearest-even of a normalized mantissa.
// Inf/NaN exponents bypass rounding and raise no flags.
module fp_rne_round #(
  parameter int EXP_W = fp_pkg::EXP_W,
  parameter int MAN_W = fp_pkg::MAN_W
) (
  input  logic [EXP_W-1:0] exp,
  input  logic [MAN_W-1:0] mant,
  input  fp_pkg::grs_t     grs,
  output logic [MAN_W-1:0] mant_rnd,
  output logic             exp_carry,
  output logic             inexact
);

  logic               special_s;
  logic               round_up_s;
  logic [MAN_W:0]     sum_s;

  // Round-up decision, mantissa increment and special-value bypass
  always_comb begin
    special_s  = (exp == {EXP_W{1'b1}});
    round_up_s = grs[2] & (grs[1] | grs[0] | mant[0]);
    sum_s      = {1'b0, mant} + {{MAN_W{1'b0}}, round_up_s};
    if (special_s) begin
      mant_rnd  = mant;
      exp_carry = 1'b0;
      inexact   = 1'b0;
    end else begin
      exp_carry = sum_s[MAN_W];
      inexact   = |grs;
      if (sum_s[MAN_W]) begin
        mant_rnd = {MAN_W{1'b0}};
      end else begin
        mant_rnd = sum_s[MAN_W-1:0];
      end
    end
  end

endmodule

// File: rtl/fp_round_pack.sv
// Round/pack stage of the FP adder: RNE rounding in S1, overflow resolution
// and packing in S2, with sticky exception flags and a result counter.
module fp_round_pack #(
  parameter int EXP_W = fp_pkg::EXP_W,
  parameter int MAN_W = fp_pkg::MAN_W,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   norm_sign,
  input  logic [EXP_W-1:0]       norm_exp,
  input  logic [MAN_W-1:0]       norm_mant,
  input  fp_pkg::grs_t           norm_grs,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   res_ovf,
  output logic                   res_inexact,
  input  logic                   flag_clr,
  output logic [1:0]             sticky_flags,
  output logic [CNT_W-1:0]       result_count
);

  import fp_pkg::*;

  localparam logic [EXP_W-1:0] exp_max_c = {EXP_W{1'b1}};

  logic               s2_free_s;
  logic               s1_free_s;
  logic               in_xfer_s;
  logic               out_xfer_s;

  logic [MAN_W-1:0]   rnd_mant_s;
  logic               rnd_carry_s;
  logic               rnd_inexact_s;

  logic               s1_v_r;
  logic               s1_sign_r;
  logic [EXP_W:0]     s1_exp_r;
  logic [MAN_W-1:0]   s1_mant_r;
  logic               s1_inexact_r;
  logic               s1_special_r;

  fp_word_t           s2_word_s;
  logic               s2_ovf_s;
  logic               s2_inexact_s;

  logic               s2_v_r;
  fp_word_t           s2_word_r;
  logic               s2_ovf_r;
  logic               s2_inexact_r;

  logic [1:0]         sticky_r;
  logic [1:0]         new_flags_s;
  logic [CNT_W-1:0]   count_r;

  assign s2_free_s  = ~s2_v_r | out_ready;
  assign s1_free_s  = ~s1_v_r | s2_free_s;
  assign in_ready   = s1_free_s & ~reset;
  assign in_xfer_s  = in_valid & in_ready;
  assign out_xfer_s = s2_v_r & out_ready;

  fp_rne_round #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_round (
    .exp       (norm_exp),
    .mant      (norm_mant),
    .grs       (norm_grs),
    .mant_rnd  (rnd_mant_s),
    .exp_carry (rnd_carry_s),
    .inexact   (rnd_inexact_s)
  );

  // S1 register: rounded mantissa and carry-adjusted exponent
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_v_r       <= 1'b0;
      s1_sign_r    <= 1'b0;
      s1_exp_r     <= {(EXP_W+1){1'b0}};
      s1_mant_r    <= {MAN_W{1'b0}};
      s1_inexact_r <= 1'b0;
      s1_special_r <= 1'b0;
    end else if (s1_free_s) begin
      s1_v_r <= in_xfer_s;
      if (in_xfer_s) begin
        s1_sign_r    <= norm_sign;
        s1_exp_r     <= {1'b0, norm_exp} + {{EXP_W{1'b0}}, rnd_carry_s};
        s1_mant_r    <= rnd_mant_s;
        s1_inexact_r <= rnd_inexact_s;
        s1_special_r <= (norm_exp == exp_max_c);
      end
    end
  end

  // A finite input whose rounded exponent reaches all-ones saturates to infinity
  always_comb begin
    s2_word_s      = '0;
    s2_word_s.sign = s1_sign_r;
    s2_ovf_s       = ~s1_special_r & (s1_exp_r >= {1'b0, exp_max_c});
    if (s2_ovf_s) begin
      s2_word_s.exp  = exp_max_c;
      s2_word_s.mant = {MAN_W{1'b0}};
      s2_inexact_s   = 1'b1;
    end else begin
      s2_word_s.exp  = s1_exp_r[EXP_W-1:0];
      s2_word_s.mant = s1_mant_r;
      s2_inexact_s   = s1_inexact_r;
    end
  end

  // S2 register: packed result and per-result flags, held under backpressure
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_v_r       <= 1'b0;
      s2_word_r    <= '0;
      s2_ovf_r     <= 1'b0;
      s2_inexact_r <= 1'b0;
    end else if (s2_free_s) begin
      s2_v_r <= s1_v_r;
      if (s1_v_r) begin
        s2_word_r    <= s2_word_s;
        s2_ovf_r     <= s2_ovf_s;
        s2_inexact_r <= s2_inexact_s;
      end
    end
  end

  always_comb begin
    new_flags_s          = 2'b00;
    new_flags_s[FLG_OVF] = s2_ovf_r;
    new_flags_s[FLG_INX] = s2_inexact_r;
  end

  // Sticky flags: a clear coinciding with a transfer keeps that transfer's flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sticky_r <= 2'b00;
    end else if (out_xfer_s) begin
      if (flag_clr) begin
        sticky_r <= new_flags_s;
      end else begin
        sticky_r <= sticky_r | new_flags_s;
      end
    end else if (flag_clr) begin
      sticky_r <= 2'b00;
    end
  end

  // Handed-off result counter, wraps naturally
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= {CNT_W{1'b0}};
    end else if (out_xfer_s) begin
      count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign out_valid    = s2_v_r;
  assign result       = s2_word_r;
  assign res_ovf      = s2_ovf_r;
  assign res_inexact  = s2_inexact_r;
  assign sticky_flags = sticky_r;
  assign result_count = count_r;

endmodule
